// File: rtl/player_executor.sv
// player_executor
//   Holds the player soul's architectural state: hit points, position inside the
//   dodge box, the invulnerability window and the sticky death flag. It executes
//   the instruction word issued by the game-state machine.
//
// Ports
//   clk               system clock
//   reset             synchronous, active-high reset (priority over all inputs)
//   playerInstruction [15:12] opcode, [11:4] operand, [3:0] unused
//   isMove            qualifies the MOV opcode (held to keep moving)
//   startDmg          one-cycle strobe qualifying HPY / DPY
//   hp                current hit points
//   posX, posY        soul coordinates in pixels
//   isDeath           sticky death flag, cleared only by SHP or reset
//   invincible        hit window running or god mode on
//   hpUpdated         one-cycle pulse whenever hp changes value
module player_executor #(
    parameter int HP_MAX   = 100,
    parameter int X_MIN    = 220,
    parameter int X_MAX    = 420,
    parameter int Y_MIN    = 250,
    parameter int Y_MAX    = 400,
    parameter int STEP     = 2,
    parameter int MOVE_DIV = 500000,
    parameter int IFRAMES  = 50000000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [15:0] playerInstruction,
    input  logic        isMove,
    input  logic        startDmg,
    output logic [7:0]  hp,
    output logic [9:0]  posX,
    output logic [9:0]  posY,
    output logic        isDeath,
    output logic        invincible,
    output logic        hpUpdated
);

    localparam int MV_W = $clog2(MOVE_DIV);
    localparam int IF_W = $clog2(IFRAMES + 1);

    localparam logic [MV_W-1:0]    MV_LAST = MV_W'(MOVE_DIV - 1);
    localparam logic [IF_W-1:0]    IF_LOAD = IF_W'(IFRAMES - 1);
    localparam logic [7:0]         HP_TOP  = 8'(HP_MAX);
    localparam logic [9:0]         X_CTR   = 10'((X_MIN + X_MAX) / 2);
    localparam logic [9:0]         Y_CTR   = 10'((Y_MIN + Y_MAX) / 2);
    localparam logic signed [10:0] STEP_S  = 11'(STEP);

    localparam logic [3:0] OP_HPY = 4'd1;
    localparam logic [3:0] OP_DPY = 4'd2;
    localparam logic [3:0] OP_IDG = 4'd3;
    localparam logic [3:0] OP_MOV = 4'd5;
    localparam logic [3:0] OP_SHP = 4'd6;

    logic [3:0] opcode;
    logic [7:0] operand;
    logic       unused_bits;

    assign opcode      = playerInstruction[15:12];
    assign operand     = playerInstruction[11:4];
    assign unused_bits = ^playerInstruction[3:0];

    logic            god;
    logic [MV_W-1:0] mv_cnt;
    logic [IF_W-1:0] if_cnt;

    logic [7:0]      hp_n;
    logic [9:0]      x_n, y_n;
    logic            dead_n, god_n, inv_n;
    logic [MV_W-1:0] mv_n;
    logic [IF_W-1:0] if_n;

    // Heal with a 9-bit sum so hp + operand cannot wrap before saturating.
    function automatic logic [7:0] heal_sat(input logic [7:0] cur, input logic [7:0] amt);
        logic [8:0] s;
        s = {1'b0, cur} + {1'b0, amt};
        return (s > {1'b0, HP_TOP}) ? HP_TOP : s[7:0];
    endfunction

    function automatic logic [7:0] dmg_sat(input logic [7:0] cur, input logic [7:0] amt);
        return (cur > amt) ? (cur - amt) : 8'd0;
    endfunction

    // Signed 11-bit step so a move below 0 clamps instead of wrapping.
    function automatic logic [9:0] step_clamp(input logic [9:0] pos,
                                              input logic signed [10:0] delta,
                                              input int lo, input int hi);
        logic signed [10:0] p;
        p = $signed({1'b0, pos}) + delta;
        if (p < $signed(11'(lo)))
            p = $signed(11'(lo));
        else if (p > $signed(11'(hi)))
            p = $signed(11'(hi));
        return p[9:0];
    endfunction

    always_comb begin
        hp_n   = hp;
        x_n    = posX;
        y_n    = posY;
        dead_n = isDeath;
        god_n  = god;
        mv_n   = '0;
        if_n   = (if_cnt != '0) ? if_cnt - 1'b1 : '0;
        // A running window keeps invincible high through the cycle the count hits 0,
        // giving exactly IFRAMES visible cycles per hit.
        inv_n  = (if_cnt != '0);
        case (opcode)
            OP_HPY: if (startDmg) hp_n = heal_sat(hp, operand);
            OP_DPY: begin
                if (startDmg && !invincible && !isDeath) begin
                    hp_n  = dmg_sat(hp, operand);
                    if_n  = IF_LOAD;
                    inv_n = 1'b1;
                    if (hp_n == 8'd0) dead_n = 1'b1;
                end
            end
            OP_IDG: god_n = (operand != 8'd0);
            OP_MOV: begin
                if (isMove) begin
                    if (mv_cnt == MV_LAST) begin
                        if (!isDeath) begin
                            case (operand[1:0])
                                2'd0: y_n = step_clamp(posY, -STEP_S, Y_MIN, Y_MAX);
                                2'd1: x_n = step_clamp(posX, -STEP_S, X_MIN, X_MAX);
                                2'd2: y_n = step_clamp(posY,  STEP_S, Y_MIN, Y_MAX);
                                default: x_n = step_clamp(posX, STEP_S, X_MIN, X_MAX);
                            endcase
                        end
                    end else begin
                        mv_n = mv_cnt + 1'b1;
                    end
                end
            end
            OP_SHP: begin
                hp_n   = (operand > HP_TOP) ? HP_TOP : operand;
                x_n    = X_CTR;
                y_n    = Y_CTR;
                dead_n = 1'b0;
                if_n   = '0;
                inv_n  = 1'b0;
            end
            default: ;
        endcase
        inv_n = inv_n | god_n;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            hp         <= HP_TOP;
            posX       <= X_CTR;
            posY       <= Y_CTR;
            isDeath    <= 1'b0;
            invincible <= 1'b0;
            hpUpdated  <= 1'b0;
            god        <= 1'b0;
            mv_cnt     <= '0;
            if_cnt     <= '0;
        end else begin
            hp         <= hp_n;
            posX       <= x_n;
            posY       <= y_n;
            isDeath    <= dead_n;
            invincible <= inv_n;
            hpUpdated  <= (hp_n != hp);
            god        <= god_n;
            mv_cnt     <= mv_n;
            if_cnt     <= if_n;
        end
    end

endmodule

// File: tb/tb_player_executor.sv
module tb_player_executor;

    localparam int IFR  = 20;
    localparam int MDIV = 4;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [15:0] instr = 16'h0;
    logic        isMove = 1'b0;
    logic        startDmg = 1'b0;
    logic [7:0]  hp;
    logic [9:0]  posX, posY;
    logic        isDeath, invincible, hpUpdated;

    player_executor #(.MOVE_DIV(MDIV), .IFRAMES(IFR)) dut (
        .clk(clk), .reset(reset), .playerInstruction(instr), .isMove(isMove),
        .startDmg(startDmg), .hp(hp), .posX(posX), .posY(posY),
        .isDeath(isDeath), .invincible(invincible), .hpUpdated(hpUpdated)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    // Behavioural model state: rem = visible window cycles still to come.
    int m_hp, m_x, m_y, m_hold, m_rem;
    bit m_dead, m_god, m_upd;
    bit m_valid = 1'b0;

    task automatic cmp(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, exp, $time);
        end
    endtask

    function automatic int clampi(input int v, input int lo, input int hi);
        return (v < lo) ? lo : ((v > hi) ? hi : v);
    endfunction

    task automatic model_step();
        int op, opd, old;
        bit inv;
        if (reset) begin
            m_hp = 100; m_x = 320; m_y = 325; m_dead = 0; m_god = 0;
            m_rem = 0; m_hold = 0; m_upd = 0; m_valid = 1;
            return;
        end
        op  = int'(instr[15:12]);
        opd = int'(instr[11:4]);
        old = m_hp;
        inv = m_god || (m_rem > 0);
        if (m_rem > 0) m_rem--;
        case (op)
            1: if (startDmg) m_hp = (m_hp + opd > 100) ? 100 : m_hp + opd;
            2: if (startDmg && !inv && !m_dead) begin
                   m_hp  = (m_hp - opd < 0) ? 0 : m_hp - opd;
                   m_rem = IFR;
                   if (m_hp == 0) m_dead = 1;
               end
            3: m_god = (opd != 0);
            5: if (isMove) begin
                   m_hold++;
                   if (m_hold == MDIV) begin
                       m_hold = 0;
                       if (!m_dead) begin
                           case (opd % 4)
                               0: m_y = clampi(m_y - 2, 250, 400);
                               1: m_x = clampi(m_x - 2, 220, 420);
                               2: m_y = clampi(m_y + 2, 250, 400);
                               default: m_x = clampi(m_x + 2, 220, 420);
                           endcase
                       end
                   end
               end
            6: begin
                   m_hp = (opd > 100) ? 100 : opd;
                   m_x = 320; m_y = 325; m_dead = 0; m_rem = 0;
               end
            default: ;
        endcase
        if (!(op == 5 && isMove)) m_hold = 0;
        m_upd = (m_hp != old);
    endtask

    initial forever begin
        @(posedge clk);
        model_step();
    end

    initial forever begin
        @(negedge clk);
        if (m_valid) begin
            cmp("hp", 32'(hp), 32'(m_hp));
            cmp("posX", 32'(posX), 32'(m_x));
            cmp("posY", 32'(posY), 32'(m_y));
            cmp("isDeath", 32'(isDeath), 32'(m_dead));
            cmp("invincible", 32'(invincible), 32'(m_god || (m_rem > 0)));
            cmp("hpUpdated", 32'(hpUpdated), 32'(m_upd));
        end
    end

    task automatic drive(input int op, input int opd, input bit mv, input bit sd);
        instr    = {op[3:0], opd[7:0], 4'h0};
        isMove   = mv;
        startDmg = sd;
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
        #1;
    endtask

    int inv_cycles;

    initial begin
        drive(0, 0, 0, 0);
        reset = 1'b1;
        tick(2);
        reset = 1'b0;
        tick(10);
        cmp("lit_reset_hp", 32'(hp), 100);
        cmp("lit_reset_x", 32'(posX), 320);
        cmp("lit_reset_y", 32'(posY), 325);
        cmp("lit_reset_dead", 32'(isDeath), 0);
        cmp("lit_reset_inv", 32'(invincible), 0);

        drive(6, 150, 0, 0); tick(1);
        cmp("lit_shp150", 32'(hp), 100);

        // Hit, then a second hit on the 10th window cycle must be ignored.
        drive(2, 30, 0, 1); tick(1);
        cmp("lit_dpy_hp", 32'(hp), 70);
        cmp("lit_dpy_upd", 32'(hpUpdated), 1);
        inv_cycles = int'(invincible);
        for (int i = 1; i < 30; i++) begin
            if (i == 9) drive(2, 30, 0, 1); else drive(0, 0, 0, 0);
            tick(1);
            inv_cycles += int'(invincible);
            if (i == 9) cmp("lit_dpy_ignored", 32'(hp), 70);
        end
        cmp("lit_iframe_len", 32'(inv_cycles), IFR);

        drive(1, 10, 0, 0); tick(1); cmp("lit_hpy_nostrobe", 32'(hp), 70);
        drive(1, 10, 0, 1); tick(1); cmp("lit_hpy10", 32'(hp), 80);
        drive(1, 50, 0, 1); tick(1); cmp("lit_hpy_sat", 32'(hp), 100);
        drive(1, 50, 0, 1); tick(1);
        cmp("lit_hpy_top", 32'(hp), 100);
        cmp("lit_hpy_top_upd", 32'(hpUpdated), 0);

        drive(6, 20, 0, 0); tick(1); cmp("lit_shp20", 32'(hp), 20);
        drive(2, 25, 0, 1); tick(1);
        cmp("lit_kill_hp", 32'(hp), 0);
        cmp("lit_kill_dead", 32'(isDeath), 1);
        drive(5, 3, 1, 0); tick(10);
        cmp("lit_dead_nomove", 32'(posX), 320);
        drive(6, 100, 0, 0); tick(1);
        cmp("lit_revive_dead", 32'(isDeath), 0);
        cmp("lit_revive_hp", 32'(hp), 100);
        cmp("lit_revive_x", 32'(posX), 320);
        cmp("lit_revive_y", 32'(posY), 325);

        // 48 steps of 2 from 320 reaches 416; then two more steps hit the wall.
        drive(5, 3, 1, 0); tick(192);
        cmp("lit_move_416", 32'(posX), 416);
        tick(4);  cmp("lit_move_418", 32'(posX), 418);
        tick(16); cmp("lit_move_clamp", 32'(posX), 420);
        drive(5, 3, 0, 0); tick(1);

        drive(5, 0, 1, 0); tick(3);
        drive(5, 0, 0, 0); tick(1);
        drive(5, 0, 1, 0); tick(3);
        cmp("lit_restart_nostep", 32'(posY), 325);
        tick(1);
        cmp("lit_restart_step", 32'(posY), 323);
        drive(5, 1, 1, 0); tick(3);
        drive(5, 2, 1, 0); tick(1);
        cmp("lit_dirchange_y", 32'(posY), 325);
        cmp("lit_dirchange_x", 32'(posX), 420);
        drive(0, 0, 0, 0); tick(1);

        drive(3, 1, 0, 0); tick(1);
        cmp("lit_god_inv", 32'(invincible), 1);
        repeat (3) begin
            drive(2, 50, 0, 1); tick(1);
            cmp("lit_god_hp", 32'(hp), 100);
        end
        drive(3, 0, 0, 0); tick(1);
        cmp("lit_god_off", 32'(invincible), 0);
        drive(2, 10, 0, 1); tick(1);
        cmp("lit_hit90", 32'(hp), 90);
        drive(0, 0, 0, 0); tick(3);
        reset = 1'b1; tick(1);
        cmp("lit_rst_hp", 32'(hp), 100);
        cmp("lit_rst_inv", 32'(invincible), 0);
        reset = 1'b0; tick(2);
        cmp("lit_rst_window_gone", 32'(invincible), 0);
        drive(2, 10, 0, 1); tick(1);
        cmp("lit_rst_god_cleared", 32'(hp), 90);
        drive(0, 0, 0, 0); tick(3);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
